ar_addr_router: RTL and testbench

Registered, parametrised AXI4 read-address router that sits between the read-address arbiter and `NUM_SLAVES` slave ports. It decodes ARADDR against a per-slave base/mask address map and holds each accepted request in a one-entry register stage with full-throughput handshaking. Unmapped addresses are answered by an internal DECERR responder that generates `arlen+1` R beats. It supersedes the fixed 4-slave, MSB-decoded, combinational AR decoder.

---
 rtl/ar_addr_router.sv | 208 ++++++++++++++++++++
 tb/tb_ar_addr_router.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_addr_router.sv
// AXI4 AR router: base/mask decode into a one-entry register stage, plus DECERR R-beat responder for unmapped addresses.
// Latency 1 cycle to m_ar*/de_r*; s_arready follows only the held slave's m_arready, so accept and release can share a cycle.
module ar_addr_router #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 1,
    parameter int LEN_W      = 8,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {4{32'hC000_0000}}
) (
    input  logic                        ACLK,
    input  logic                        ARESET,

    input  logic [ID_W-1:0]             s_arid,
    input  logic [ADDR_W-1:0]           s_araddr,
    input  logic [LEN_W-1:0]            s_arlen,
    input  logic [2:0]                  s_arsize,
    input  logic [1:0]                  s_arburst,
    input  logic [1:0]                  s_arlock,
    input  logic [3:0]                  s_arcache,
    input  logic [2:0]                  s_arprot,
    input  logic [3:0]                  s_arqos,
    input  logic [3:0]                  s_arregion,
    input  logic                        s_arvalid,
    output logic                        s_arready,

    output logic [NUM_SLAVES*ID_W-1:0]   m_arid,
    output logic [NUM_SLAVES*ADDR_W-1:0] m_araddr,
    output logic [NUM_SLAVES*LEN_W-1:0]  m_arlen,
    output logic [NUM_SLAVES*3-1:0]      m_arsize,
    output logic [NUM_SLAVES*2-1:0]      m_arburst,
    output logic [NUM_SLAVES*2-1:0]      m_arlock,
    output logic [NUM_SLAVES*4-1:0]      m_arcache,
    output logic [NUM_SLAVES*3-1:0]      m_arprot,
    output logic [NUM_SLAVES*4-1:0]      m_arqos,
    output logic [NUM_SLAVES*4-1:0]      m_arregion,
    output logic [NUM_SLAVES-1:0]        m_arvalid,
    input  logic [NUM_SLAVES-1:0]        m_arready,

    output logic [ID_W-1:0]             de_rid,
    output logic [DATA_W-1:0]           de_rdata,
    output logic [1:0]                  de_rresp,
    output logic                        de_rlast,
    output logic                        de_rvalid,
    input  logic                        de_rready,

    output logic [NUM_SLAVES-1:0]       sel_onehot,
    output logic                        decerr_active
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    logic [1:0]        r_state;
    logic              r_live;
    logic [SEL_W-1:0]  r_sel;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [1:0]        r_lock;
    logic [3:0]        r_cache;
    logic [2:0]        r_prot;
    logic [3:0]        r_qos;
    logic [3:0]        r_region;
    logic [LEN_W-1:0]  r_cnt;

    logic              w_hit;
    logic [SEL_W-1:0]  w_sel;
    logic [NUM_SLAVES-1:0] w_held_oh;
    logic              w_held_rdy;
    logic              w_acc;
    logic              w_rel;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((s_araddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                w_hit = 1'b1;
                w_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_held_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_held_oh[i] = (r_sel == SEL_W'(i));
        end
    end

    assign w_held_rdy = |(m_arready & w_held_oh);
    assign sel_onehot = (r_state == ST_HOLD) ? w_held_oh : '0;
    assign m_arvalid  = sel_onehot;

    // r_live keeps s_arready low through the reset cycle without a path from ARESET.
    always_comb begin
        case (r_state)
            ST_EMPTY: s_arready = r_live;
            ST_HOLD:  s_arready = w_held_rdy;
            default:  s_arready = 1'b0;
        endcase
    end

    assign w_acc = s_arvalid & s_arready;
    assign w_rel = (r_state == ST_HOLD) & w_held_rdy;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= ST_EMPTY;
            r_live   <= 1'b0;
            r_sel    <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_lock   <= '0;
            r_cache  <= '0;
            r_prot   <= '0;
            r_qos    <= '0;
            r_region <= '0;
            r_cnt    <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_state <= w_hit ? ST_HOLD : ST_ERR;
                    end
                end
                ST_HOLD: begin
                    if (w_rel) begin
                        r_state <= w_acc ? (w_hit ? ST_HOLD : ST_ERR) : ST_EMPTY;
                    end
                end
                ST_ERR: begin
                    if (de_rready) begin
                        if (r_cnt == '0) begin
                            r_state <= ST_EMPTY;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
            // s_arready is low in ERR, so this load never collides with the countdown.
            if (w_acc) begin
                r_sel    <= w_sel;
                r_id     <= s_arid;
                r_addr   <= s_araddr;
                r_len    <= s_arlen;
                r_size   <= s_arsize;
                r_burst  <= s_arburst;
                r_lock   <= s_arlock;
                r_cache  <= s_arcache;
                r_prot   <= s_arprot;
                r_qos    <= s_arqos;
                r_region <= s_arregion;
                r_cnt    <= s_arlen;
            end
        end
    end

    always_comb begin
        m_arid     = '0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = '0;
        m_arlock   = '0;
        m_arcache  = '0;
        m_arprot   = '0;
        m_arqos    = '0;
        m_arregion = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_onehot[i]) begin
                m_arid[i*ID_W +: ID_W]       = r_id;
                m_araddr[i*ADDR_W +: ADDR_W] = r_addr;
                m_arlen[i*LEN_W +: LEN_W]    = r_len;
                m_arsize[i*3 +: 3]           = r_size;
                m_arburst[i*2 +: 2]          = r_burst;
                m_arlock[i*2 +: 2]           = r_lock;
                m_arcache[i*4 +: 4]          = r_cache;
                m_arprot[i*3 +: 3]           = r_prot;
                m_arqos[i*4 +: 4]            = r_qos;
                m_arregion[i*4 +: 4]         = r_region;
            end
        end
    end

    assign decerr_active = (r_state == ST_ERR);
    assign de_rvalid     = decerr_active;
    assign de_rresp      = decerr_active ? 2'b11 : 2'b00;
    assign de_rid        = decerr_active ? r_id : '0;
    assign de_rdata      = '0;
    assign de_rlast      = decerr_active && (r_cnt == '0);

endmodule

// File: tb/tb_ar_addr_router.sv
// Bench for ar_addr_router: decode table, hand-written corner sequences, then random traffic against a transaction model.
module tb_ar_addr_router;

    localparam logic [127:0] BASE_A = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK_A = {32'h0000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};
    localparam logic [127:0] BASE_B = {32'hC000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [127:0] MASK_B = {4{32'hC000_0000}};

    logic ACLK, ARESET;
    logic [0:0] s_arid;
    logic [31:0] s_araddr;
    logic [7:0] s_arlen;
    logic [2:0] s_arsize, s_arprot;
    logic [1:0] s_arburst, s_arlock;
    logic [3:0] s_arcache, s_arqos, s_arregion;
    logic s_arvalid, s_arready, ov_arvalid, ov_arready;
    logic [3:0] m_arid, ov_arid;
    logic [127:0] m_araddr, ov_araddr;
    logic [31:0] m_arlen, ov_arlen;
    logic [11:0] m_arsize, m_arprot, ov_arsize, ov_arprot;
    logic [7:0] m_arburst, m_arlock, ov_arburst, ov_arlock;
    logic [15:0] m_arcache, m_arqos, m_arregion, ov_arcache, ov_arqos, ov_arregion;
    logic [3:0] m_arvalid, m_arready, ov_m_arvalid;
    logic [0:0] de_rid, ov_rid;
    logic [31:0] de_rdata, ov_rdata;
    logic [1:0] de_rresp, ov_rresp;
    logic de_rlast, de_rvalid, de_rready, ov_rlast, ov_rvalid;
    logic [3:0] sel_onehot, ov_sel_onehot;
    logic decerr_active, ov_decerr;

    int n_cmp = 0;
    int n_bad = 0;

    ar_addr_router #(.SLAVE_BASE(BASE_A), .SLAVE_MASK(MASK_A)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .de_rid(de_rid), .de_rdata(de_rdata), .de_rresp(de_rresp), .de_rlast(de_rlast),
        .de_rvalid(de_rvalid), .de_rready(de_rready),
        .sel_onehot(sel_onehot), .decerr_active(decerr_active)
    );

    // Second map with slaves 0 and 1 overlapping, for the priority rule.
    ar_addr_router #(.SLAVE_BASE(BASE_B), .SLAVE_MASK(MASK_B)) dut_ov (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arvalid(ov_arvalid), .s_arready(ov_arready),
        .m_arid(ov_arid), .m_araddr(ov_araddr), .m_arlen(ov_arlen), .m_arsize(ov_arsize),
        .m_arburst(ov_arburst), .m_arlock(ov_arlock), .m_arcache(ov_arcache), .m_arprot(ov_arprot),
        .m_arqos(ov_arqos), .m_arregion(ov_arregion), .m_arvalid(ov_m_arvalid), .m_arready(m_arready),
        .de_rid(ov_rid), .de_rdata(ov_rdata), .de_rresp(ov_rresp), .de_rlast(ov_rlast),
        .de_rvalid(ov_rvalid), .de_rready(de_rready),
        .sel_onehot(ov_sel_onehot), .decerr_active(ov_decerr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lowest matching slice wins; 4 means no slave claims the address.
    function automatic int ref_decode(input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            if ((a & MASK_A[k*32 +: 32]) == BASE_A[k*32 +: 32]) return k;
        end
        return 4;
    endfunction

    function automatic logic [62:0] dut_slice(input int k);
        return {m_arid[k], m_araddr[k*32 +: 32], m_arlen[k*8 +: 8], m_arsize[k*3 +: 3],
                m_arburst[k*2 +: 2], m_arlock[k*2 +: 2], m_arcache[k*4 +: 4],
                m_arprot[k*3 +: 3], m_arqos[k*4 +: 4], m_arregion[k*4 +: 4]};
    endfunction

    task automatic drain();
        int c;
        s_arvalid = 1'b0;
        ov_arvalid = 1'b0;
        m_arready = 4'hF;
        de_rready = 1'b1;
        c = 0;
        do begin
            @(posedge ACLK); #1;
            c++;
        end while ((sel_onehot != 0 || decerr_active) && c < 400);
        chk("drain_idle", (c < 400), 1);
        m_arready = 4'h0;
        de_rready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  exp_oh;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          dest;
        logic [62:0] fields;
        logic [0:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        int          beats;
    } req_t;

    vec_t tbl[8];
    req_t q[$];

    initial begin
        logic [127:0] exp_addr;
        logic [4:0] pat;
        int beats, n_map, n_err;
        logic exp_rdy;
        req_t r;

        tbl[0] = '{32'h0000_0004, 8'd0, 4'b0001, 1'b0};
        tbl[1] = '{32'h3FFF_FFFF, 8'd1, 4'b0001, 1'b0};
        tbl[2] = '{32'h4000_0000, 8'd2, 4'b0010, 1'b0};
        tbl[3] = '{32'h7FFF_FFFC, 8'd3, 4'b0010, 1'b0};
        tbl[4] = '{32'h8000_0010, 8'd4, 4'b0100, 1'b0};
        tbl[5] = '{32'hBFFF_FFFF, 8'd5, 4'b0100, 1'b0};
        tbl[6] = '{32'hC000_0000, 8'd0, 4'b0000, 1'b1};
        tbl[7] = '{32'hF000_0000, 8'd1, 4'b0000, 1'b1};

        ARESET = 1'b1; s_arvalid = 0; ov_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0;
        s_arsize = 0; s_arburst = 0; s_arlock = 0; s_arcache = 0; s_arprot = 0; s_arqos = 0;
        s_arregion = 0; m_arready = 0; de_rready = 0;

        // Reset values
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arready", s_arready, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_sel", sel_onehot, 0);
        chk("rst_de", {de_rvalid, de_rlast, de_rresp, de_rid, de_rdata, decerr_active}, 0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("idle_arready", s_arready, 1);
        chk("idle_arvalid", m_arvalid, 0);

        // Decode table
        for (int i = 0; i < 8; i++) begin
            @(posedge ACLK); #1;
            s_arvalid = 1; s_araddr = tbl[i].addr; s_arlen = tbl[i].len; s_arid = 1'(i);
            m_arready = 0; de_rready = 0;
            @(negedge ACLK);
            chk("tbl_rdy", s_arready, 1);
            @(posedge ACLK); #1 s_arvalid = 0;
            @(negedge ACLK);
            exp_addr = '0;
            for (int k = 0; k < 4; k++) if (tbl[i].exp_oh[k]) exp_addr[k*32 +: 32] = tbl[i].addr;
            chk("tbl_sel", sel_onehot, tbl[i].exp_oh);
            chk("tbl_err", decerr_active, tbl[i].exp_err);
            chk("tbl_addr", m_araddr, exp_addr);
            drain();
        end

        // Route to slave 2
        @(posedge ACLK); #1;
        s_arvalid = 1; s_araddr = 32'h8000_0010; s_arlen = 3; s_arid = 0; m_arready = 4'b0100;
        @(posedge ACLK); #1 s_arvalid = 0;
        @(negedge ACLK);
        chk("r2_valid", m_arvalid, 4'b0100);
        chk("r2_addr", m_araddr, {32'h0, 32'h8000_0010, 64'h0});
        chk("r2_len", m_arlen, {8'h0, 8'h3, 16'h0});
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("r2_released", m_arvalid, 0);
        drain();

        // Backpressure, then release with back-to-back accept
        @(posedge ACLK); #1;
        s_arvalid = 1; s_araddr = 32'h4000_0000; s_arlen = 1; s_arid = 1; m_arready = 0;
        @(posedge ACLK); #1 s_araddr = 32'h0000_0004;
        for (int j = 0; j < 5; j++) begin
            @(negedge ACLK);
            chk("bp_valid", m_arvalid, 4'b0010);
            chk("bp_addr", m_araddr, {64'h0, 32'h4000_0000, 32'h0});
            chk("bp_rdy", s_arready, 0);
            @(posedge ACLK); #1;
        end
        m_arready = 4'b0010;
        @(negedge ACLK);
        chk("bp_rdy_follow", s_arready, 1);
        @(posedge ACLK); #1 s_arvalid = 0;
        @(negedge ACLK);
        chk("b2b_valid", m_arvalid, 4'b0001);
        chk("b2b_addr", m_araddr, {96'h0, 32'h0000_0004});
        drain();

        // DECERR with de_rready toggling
        @(posedge ACLK); #1;
        s_arvalid = 1; s_araddr = 32'hF000_0000; s_arlen = 2; s_arid = 1; de_rready = 0;
        @(posedge ACLK); #1 s_arvalid = 0;
        pat = 5'b10101;
        beats = 0;
        for (int j = 0; j < 5; j++) begin
            de_rready = pat[j];
            @(negedge ACLK);
            chk("de_valid", de_rvalid, 1);
            chk("de_id_resp", {de_rid, de_rresp, de_rdata}, {1'b1, 2'b11, 32'h0});
            chk("de_last", de_rlast, (beats == 2));
            chk("de_rdy", s_arready, 0);
            if (pat[j]) beats++;
            @(posedge ACLK); #1;
        end
        de_rready = 0;
        @(negedge ACLK);
        chk("de_done_valid", de_rvalid, 0);
        chk("de_done_rdy", s_arready, 1);

        // arlen 255 gives 256 beats; s_arready returns the cycle after the last
        @(posedge ACLK); #1;
        s_arvalid = 1; s_araddr = 32'hD000_0000; s_arlen = 8'd255; s_arid = 0; de_rready = 1;
        @(posedge ACLK); #1 s_arvalid = 0;
        beats = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge ACLK);
            if (!(de_rvalid && de_rready)) break;
            beats++;
            if (de_rlast) begin
                @(negedge ACLK);
                break;
            end
        end
        chk("len255_beats", beats, 256);
        chk("len255_rdy_back", s_arready, 1);
        de_rready = 0;

        // Overlapping map: lowest index wins
        @(posedge ACLK); #1;
        ov_arvalid = 1; s_araddr = 32'h0000_0100; m_arready = 0;
        @(posedge ACLK); #1 ov_arvalid = 0;
        @(negedge ACLK);
        chk("prio_sel", ov_sel_onehot, 4'b0001);
        chk("prio_addr", ov_araddr, {96'h0, 32'h0000_0100});
        drain();

        // Reset in the middle of a DECERR burst
        @(posedge ACLK); #1;
        s_arvalid = 1; s_araddr = 32'hF000_0000; s_arlen = 7; s_arid = 0; de_rready = 1;
        @(posedge ACLK); #1 s_arvalid = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1;
        @(negedge ACLK);
        chk("mid_active", de_rvalid, 1);
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK);
        chk("mid_rst_valid", {de_rvalid, decerr_active}, 0);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("mid_no_beats", de_rvalid, 0);
        @(posedge ACLK); #1;
        s_arvalid = 1; s_araddr = 32'h8000_0000; m_arready = 0; de_rready = 0;
        @(posedge ACLK); #1 s_arvalid = 0;
        @(negedge ACLK);
        chk("mid_fresh_route", m_arvalid, 4'b0100);
        drain();

        // Random traffic against the transaction model
        n_map = 0; n_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge ACLK); #1;
            s_arvalid = 1'($urandom_range(0, 1));
            s_araddr = $urandom();
            s_arlen = 8'($urandom_range(0, 3));
            s_arid = 1'($urandom());
            s_arsize = 3'($urandom()); s_arburst = 2'($urandom()); s_arlock = 2'($urandom());
            s_arcache = 4'($urandom()); s_arprot = 3'($urandom()); s_arqos = 4'($urandom());
            s_arregion = 4'($urandom());
            m_arready = 4'($urandom());
            de_rready = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            if (q.size() == 0) exp_rdy = 1'b1;
            else if (q[0].dest < 4) exp_rdy = m_arready[q[0].dest];
            else exp_rdy = 1'b0;
            chk("rnd_arready", s_arready, exp_rdy);
            if (q.size() == 0) begin
                chk("rnd_idle", {m_arvalid, de_rvalid, sel_onehot}, 0);
            end else if (q[0].dest < 4) begin
                exp_addr = '0;
                exp_addr[q[0].dest*32 +: 32] = q[0].addr;
                chk("rnd_valid", {m_arvalid, sel_onehot, de_rvalid}, {4'(1 << q[0].dest), 4'(1 << q[0].dest), 1'b0});
                chk("rnd_fields", dut_slice(q[0].dest), q[0].fields);
                chk("rnd_addr_vec", m_araddr, exp_addr);
            end else begin
                chk("rnd_err_valid", {m_arvalid, de_rvalid, decerr_active}, {4'b0, 1'b1, 1'b1});
                chk("rnd_err_beat", {de_rid, de_rresp, de_rdata}, {q[0].id, 2'b11, 32'h0});
                chk("rnd_err_last", de_rlast, (q[0].beats == int'(q[0].len)));
            end
            if (q.size() > 0) begin
                if (q[0].dest < 4) begin
                    if (m_arready[q[0].dest]) begin
                        void'(q.pop_front());
                        n_map++;
                    end
                end else if (de_rready) begin
                    if (q[0].beats == int'(q[0].len)) begin
                        void'(q.pop_front());
                        n_err++;
                    end else begin
                        q[0].beats = q[0].beats + 1;
                    end
                end
            end
            if (s_arvalid && exp_rdy) begin
                r.dest = ref_decode(s_araddr);
                r.fields = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
                            s_arcache, s_arprot, s_arqos, s_arregion};
                r.id = s_arid;
                r.addr = s_araddr;
                r.len = s_arlen;
                r.beats = 0;
                q.push_back(r);
            end
        end
        chk("rnd_progress", (n_map > 100 && n_err > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
